// File: rtl/credit_tx_if.sv
// credit_tx_if: bundles the producer valid/ready handshake and the downstream
// FIFO write/credit path of credit_tx_stage.
//   in_data/in_valid/in_ready : producer -> stage handshake
//   wr_data/wr_valid          : stage -> FIFO write side
//   wr_credit                 : FIFO -> stage credit return pulse
// Modports: master = the stage's view, slave = the environment's view.
interface credit_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_credit;

    modport master (
        input  in_data, in_valid, wr_credit,
        output in_ready, wr_data, wr_valid
    );

    modport slave (
        output in_data, in_valid, wr_credit,
        input  in_ready, wr_data, wr_valid
    );
endinterface

// File: rtl/credit_tx_stage.sv
// credit_tx_stage: credit-based transmit stage feeding a DATA_W x CREDITS FIFO.
// Producer items land in a 2-entry skid buffer and are forwarded one per
// cycle only while a credit is held, so the downstream FIFO cannot overflow.
// A level flush_req drains the buffer and waits for all credits to return,
// then pulses flush_done.
// Ports:
//   clk, rstn   : clock, synchronous active-low reset
//   bus         : credit_tx_if.master (in_* handshake, wr_* write, wr_credit)
//   flush_req   : level drain request
//   flush_done  : one-cycle pulse when drain completes
//   credit_cnt  : credits currently held
//   idle        : buffer empty and all credits home (0 during INIT)
//   credit_err  : only with CREDIT_TX_OVERFLOW_CHK_EN defined; sticky flag for
//                 a credit returned while already holding CREDITS
module credit_tx_stage #(
    parameter int DATA_W  = 8,
    parameter int CREDITS = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rstn,
    credit_tx_if.master      bus,
    input  logic             flush_req,
    output logic             flush_done,
    output logic [CNT_W-1:0] credit_cnt,
    output logic             idle
`ifdef CREDIT_TX_OVERFLOW_CHK_EN
    ,
    output logic             credit_err
`endif
);

    typedef enum logic [1:0] {INIT, RUN, FLUSH} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] buf0, buf1;      // buf0 is the head
    logic [1:0]        count;
    logic              in_ready_c;
    logic              send_en;
    logic              done_nxt;
    logic              push, pop;
    logic [DATA_W-1:0] wr_data_q;
    logic              wr_valid_q;
    logic [CNT_W:0]    cred_sum;
    logic [CNT_W-1:0]  cred_nxt;

    always_comb begin
        state_nxt  = state;
        in_ready_c = 1'b0;
        send_en    = 1'b0;
        done_nxt   = 1'b0;
        case (state)
            INIT: state_nxt = RUN;
            RUN: begin
                // ready depends only on occupancy, not on a same-cycle pop
                in_ready_c = (count < 2'd2);
                send_en    = 1'b1;
                if (flush_req) state_nxt = FLUSH;
            end
            FLUSH: begin
                send_en = 1'b1;
                if (count == 2'd0 && credit_cnt == CNT_W'(CREDITS)) begin
                    state_nxt = RUN;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    assign push = bus.in_valid && in_ready_c;
    assign pop  = send_en && (count != 2'd0) && (credit_cnt != '0);

    // One extra bit so a return at CREDITS can be seen and saturated.
    // pop implies credit_cnt > 0, so the subtraction cannot wrap.
    assign cred_sum = {1'b0, credit_cnt} + (CNT_W+1)'(bus.wr_credit) - (CNT_W+1)'(pop);
    assign cred_nxt = (cred_sum > (CNT_W+1)'(CREDITS)) ? CNT_W'(CREDITS)
                                                       : cred_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= INIT;
            count      <= 2'd0;
            buf0       <= '0;
            buf1       <= '0;
            credit_cnt <= '0;
            wr_valid_q <= 1'b0;
            wr_data_q  <= '0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_done <= done_nxt;
            wr_valid_q <= pop;
            if (pop) wr_data_q <= buf0;
            // INIT loads the full budget and ignores any stray return
            credit_cnt <= (state == INIT) ? CNT_W'(CREDITS) : cred_nxt;
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) buf0 <= bus.in_data;
                    else               buf1 <= bus.in_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    buf0  <= buf1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // occupancy unchanged; new item goes behind what remains
                    if (count == 2'd1) begin
                        buf0 <= bus.in_data;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= bus.in_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_data  = wr_data_q;
    assign idle = (state != INIT) && (count == 2'd0) && (credit_cnt == CNT_W'(CREDITS));

`ifdef CREDIT_TX_OVERFLOW_CHK_EN
    // a return with the budget already full and nothing consumed this cycle
    always_ff @(posedge clk) begin
        if (!rstn)
            credit_err <= 1'b0;
        else if (state != INIT && bus.wr_credit && !pop && credit_cnt == CNT_W'(CREDITS))
            credit_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_credit_tx_stage.sv
module tb_credit_tx_stage;
    localparam int DATA_W  = 8;
    localparam int CREDITS = 16;
    localparam int CNT_W   = 5;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             flush_req = 1'b0;
    logic             flush_done;
    logic [CNT_W-1:0] credit_cnt;
    logic             idle;
`ifdef CREDIT_TX_OVERFLOW_CHK_EN
    logic             credit_err;
`endif

    credit_tx_if #(.DATA_W(DATA_W)) bus ();

    credit_tx_stage #(.DATA_W(DATA_W), .CREDITS(CREDITS), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .credit_cnt (credit_cnt),
        .idle       (idle)
`ifdef CREDIT_TX_OVERFLOW_CHK_EN
        ,
        .credit_err (credit_err)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: item queue, integer credit budget, drain flag.
    logic [7:0] mq[$];
    int         m_cred = 0;
    bit         m_init = 1;
    bit         m_flush = 0;
    bit         m_wv = 0;
    bit         m_fd = 0;
    bit         m_err = 0;
    logic [7:0] m_wd = 8'h00;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       cr;
        logic       exp_wv;
        logic [7:0] exp_wd;
        logic [4:0] exp_cnt;
        logic       exp_rdy;
        logic       exp_idle;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit v, input logic [7:0] d, input bit cr, input bit fl);
        bit rdy, snd, was_empty;
        int cpre;
        if (!rstn) begin
            mq.delete();
            m_cred = 0; m_init = 1; m_flush = 0;
            m_wv = 0; m_wd = 8'h00; m_fd = 0; m_err = 0;
            return;
        end
        if (m_init) begin
            m_init = 0; m_cred = CREDITS; m_wv = 0; m_fd = 0;
            return;
        end
        rdy       = !m_flush && mq.size() < 2;
        snd       = mq.size() > 0 && m_cred > 0;
        was_empty = mq.size() == 0;
        cpre      = m_cred;
        if (cr && cpre == CREDITS && !snd) m_err = 1;
        m_wv = snd;
        if (snd) m_wd = mq.pop_front();
        if (v && rdy) mq.push_back(d);
        m_cred = cpre - int'(snd) + int'(cr);
        if (m_cred > CREDITS) m_cred = CREDITS;
        m_fd = 0;
        if (!m_flush) m_flush = fl;
        else if (was_empty && cpre == CREDITS) begin
            m_flush = 0;
            m_fd    = 1;
        end
    endtask

    task automatic check_all();
        chk("wr_valid",   32'(bus.wr_valid), 32'(m_wv));
        chk("wr_data",    32'(bus.wr_data),  32'(m_wd));
        chk("credit_cnt", 32'(credit_cnt),   32'(m_cred));
        chk("in_ready",   32'(bus.in_ready), 32'(!m_init && !m_flush && mq.size() < 2));
        chk("flush_done", 32'(flush_done),   32'(m_fd));
        chk("idle",       32'(idle),         32'(!m_init && mq.size() == 0 && m_cred == CREDITS));
`ifdef CREDIT_TX_OVERFLOW_CHK_EN
        chk("credit_err", 32'(credit_err),   32'(m_err));
`endif
    endtask

    // Apply inputs, take one edge, advance the model, compare 1 time unit later.
    task automatic step(input bit v, input logic [7:0] d, input bit cr, input bit fl);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.wr_credit = cr;
        flush_req     = fl;
        @(posedge clk);
        model_edge(v, d, cr, fl);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);
        rstn = 1'b1;
        step(0, 8'h00, 0, 0);   // INIT edge
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt, pulses, sends, dones;
        bit acc, fl_on, done_seen;

        tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 5'd16, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 5'd15, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 5'd14, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 5'd15, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 5'd16, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 5'd16, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 8'h77, 1'b0, 1'b0, 8'h3C, 5'd16, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h77, 5'd16, 1'b1, 1'b1};

        bus.in_valid = 1'b0; bus.in_data = '0; bus.wr_credit = 1'b0;

        // reset state
        rstn = 1'b0;
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 1, 0);
        chk("rst_cnt",   32'(credit_cnt),   0);
        chk("rst_rdy",   32'(bus.in_ready), 0);
        chk("rst_wv",    32'(bus.wr_valid), 0);
        rstn = 1'b1;
        step(0, 8'h00, 1, 0);             // INIT: return ignored
        chk("init_cnt",  32'(credit_cnt),   16);
        chk("init_wv",   32'(bus.wr_valid), 0);
        step(0, 8'h00, 0, 0);
        chk("init_rdy",  32'(bus.in_ready), 1);

        // stream 0x01..0x14 with no returns
        nxt = 1; pulses = 0;
        for (int c = 0; c < 30; c++) begin
            acc = (bus.in_ready === 1'b1) && nxt <= 20;
            step(nxt <= 20, 8'(nxt), 0, 0);
            if (bus.wr_valid === 1'b1) begin
                pulses++;
                chk("stream_data", 32'(bus.wr_data), 32'(pulses));
            end
            if (acc) nxt++;
        end
        chk("stream_pulses", 32'(pulses), 16);
        chk("stream_cnt",    32'(credit_cnt), 0);
        chk("stream_rdy",    32'(bus.in_ready), 0);

        // single return at zero credits: send on the following edge
        step(0, 8'h00, 1, 0);
        chk("ret_cnt1", 32'(credit_cnt), 1);
        chk("ret_wv0",  32'(bus.wr_valid), 0);
        step(0, 8'h00, 0, 0);
        chk("ret_wv1",  32'(bus.wr_valid), 1);
        chk("ret_data", 32'(bus.wr_data), 32'h11);
        chk("ret_cnt0", 32'(credit_cnt), 0);

        // reset mid-operation (0x12 still buffered) then send+return at 5
        do_reset();
        chk("rst2_wv",  32'(bus.wr_valid), 0);
        for (int i = 0; i < 11; i++) step(1, 8'(8'h40 + i), 0, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);
        chk("cnt5", 32'(credit_cnt), 5);
        step(1, 8'h99, 0, 0);
        step(0, 8'h00, 1, 0);
        chk("sr_cnt",  32'(credit_cnt), 5);
        chk("sr_wv",   32'(bus.wr_valid), 1);
        chk("sr_data", 32'(bus.wr_data), 32'h99);

        // flush with three items in flight, one credit back per cycle
        sends = 0; dones = 0; done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            step(1, 8'(8'hA1 + i), 0, 0);
            if (bus.wr_valid === 1'b1) sends++;
        end
        for (int c = 0; c < 100 && !done_seen; c++) begin
            step(0, 8'h00, m_cred < CREDITS, 1);
            if (bus.wr_valid === 1'b1) sends++;
            if (flush_done === 1'b1) begin
                done_seen = 1; dones++;
                chk("flush_cnt",  32'(credit_cnt), 16);
                chk("flush_idle", 32'(idle), 1);
            end else begin
                chk("flush_rdy", 32'(bus.in_ready), 0);
            end
        end
        chk("flush_seen", 32'(done_seen), 1);
        for (int c = 0; c < 3; c++) begin
            step(0, 8'h00, 0, 0);
            if (flush_done === 1'b1) dones++;
        end
        chk("flush_sends", 32'(sends), 3);
        chk("flush_dones", 32'(dones), 1);

        // table-driven vectors from a fresh reset
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].cr, 0);
            chk($sformatf("tbl%0d_wv", i),   32'(bus.wr_valid), 32'(tbl[i].exp_wv));
            chk($sformatf("tbl%0d_wd", i),   32'(bus.wr_data),  32'(tbl[i].exp_wd));
            chk($sformatf("tbl%0d_cnt", i),  32'(credit_cnt),   32'(tbl[i].exp_cnt));
            chk($sformatf("tbl%0d_rdy", i),  32'(bus.in_ready), 32'(tbl[i].exp_rdy));
            chk($sformatf("tbl%0d_idle", i), 32'(idle),         32'(tbl[i].exp_idle));
        end

`ifdef CREDIT_TX_OVERFLOW_CHK_EN
        do_reset();
        chk("err_rst", 32'(credit_err), 0);
        step(0, 8'h00, 1, 0);
        chk("err_cnt", 32'(credit_cnt), 16);
        chk("err_set", 32'(credit_err), 1);
        for (int c = 0; c < 3; c++) step(1, 8'(c), 0, 0);
        chk("err_sticky", 32'(credit_err), 1);
        rstn = 1'b0;
        step(0, 8'h00, 0, 0);
        chk("err_clr", 32'(credit_err), 0);
        rstn = 1'b1;
`endif

        // randomized traffic against the model
        do_reset();
        fl_on = 0;
        for (int c = 0; c < 2000; c++) begin
            bit v, cr;
            rstn = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 39) == 0) fl_on = !fl_on;
            v  = ($urandom_range(0, 3) != 0);
            cr = (m_cred < CREDITS) ? ($urandom_range(0, 1) == 1)
                                    : ($urandom_range(0, 49) == 0);
            step(v, 8'($urandom), cr, fl_on);
        end
        rstn = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
